// File: rtl/dipsw_debounce.sv
// Per-channel 2-flop synchroniser and stability-counter debouncer for DIP switches and pushbuttons.
// Optional rejected-bounce counter enabled by defining DIPSW_DEBOUNCE_GLITCH_CNT_EN.
module dipsw_debounce #(
  parameter int               WIDTH           = 4,
  parameter int               CNT_W           = 16,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter logic [WIDTH-1:0] INIT_VAL        = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  input  logic             enable,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_change,
  output logic             busy,
  input  logic             glitch_clr,
  output logic [15:0]      glitch_count
);

  localparam logic [0:0]       IDLE     = 1'b0;
  localparam logic [0:0]       QUAL     = 1'b1;
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Handshake: none. Inputs are free-running levels; sw_change is a 1-cycle strobe
  // that is valid exactly on the cycle sw_clean changes and needs no acknowledge.

  logic [WIDTH-1:0] sync0;
  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] state_nxt;
  logic [CNT_W-1:0] cnt     [WIDTH];
  logic [CNT_W-1:0] cnt_nxt [WIDTH];
  logic [WIDTH-1:0] clean_nxt;
  logic [WIDTH-1:0] change_nxt;
  logic [WIDTH-1:0] abort;

  // Terminal compare is checked before the increment, so cnt never wraps.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      state_nxt[i]  = IDLE;
      cnt_nxt[i]    = '0;
      clean_nxt[i]  = sw_clean[i];
      change_nxt[i] = 1'b0;
      abort[i]      = 1'b0;
      if (enable) begin
        case (state[i])
          IDLE: begin
            if (sync1[i] != sw_clean[i]) begin
              state_nxt[i] = QUAL;
              cnt_nxt[i]   = CNT_W'(1);
            end
          end
          QUAL: begin
            if (sync1[i] == sw_clean[i]) begin
              abort[i] = 1'b1;
            end else if (cnt[i] == CNT_TERM) begin
              clean_nxt[i]  = sync1[i];
              change_nxt[i] = 1'b1;
            end else begin
              state_nxt[i] = QUAL;
              cnt_nxt[i]   = cnt[i] + CNT_W'(1);
            end
          end
          default: begin
            state_nxt[i] = IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync0     <= INIT_VAL;
      sync1     <= INIT_VAL;
      state     <= {WIDTH{IDLE}};
      sw_clean  <= INIT_VAL;
      sw_change <= '0;
      busy      <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync0     <= sw_raw;
      sync1     <= sync0;
      state     <= state_nxt;
      sw_clean  <= clean_nxt;
      sw_change <= change_nxt;
      busy      <= |state_nxt;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

`ifdef DIPSW_DEBOUNCE_GLITCH_CNT_EN
  logic [15:0] glitch_q;

  // Several channels aborting together still count as one rejected bounce.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      glitch_q <= 16'h0000;
    end else if (glitch_clr) begin
      glitch_q <= 16'h0000;
    end else if ((|abort) && (glitch_q != 16'hFFFF)) begin
      glitch_q <= glitch_q + 16'h0001;
    end
  end

  assign glitch_count = glitch_q;
`else
  logic unused_glitch;

  assign unused_glitch = glitch_clr ^ (|abort);
  assign glitch_count  = 16'h0000;
`endif

endmodule
